fetch_line_assembler: RTL and testbench

Fetch-side producer that builds one instruction fetch line from individual word responses returned by instruction memory. It issues word reads critical-word-first with wrap-around, places each returned word in its slot, and presents the completed line on a valid/ready port. That port feeds the downstream word-select stage. It also handles pipeline redirects (flush), including draining in-flight memory responses.

---
 rtl/banff_fetch_pkg.sv | 28 ++
 rtl/fetch_line_buf.sv | 38 +++
 rtl/fetch_line_assembler.sv | 185 ++++++++++++++++++
 tb/tb_fetch_line_assembler.sv | 491 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/banff_fetch_pkg.sv
// Shared definitions for the fetch line assembler.
// State encoding, line geometry defaults and a log2 helper.
package banff_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        PRESENT = 2'd2,
        DRAIN   = 2'd3
    } fetch_state_e;

    localparam int DEF_WORD_WIDTH     = 32;
    localparam int DEF_WORDS_PER_LINE = 4;
    localparam int DEF_ADDR_WIDTH     = 32;

    // Ceiling log2; exact for the power-of-two sizes used here.
    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fetch_line_buf.sv
// Line storage for the fetch assembler.
// One word written per cycle by slot index; whole line read flat.
module fetch_line_buf
    import banff_fetch_pkg::*;
#(
    parameter int WORD_WIDTH     = DEF_WORD_WIDTH,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 wr_en,
    input  logic [log2(WORDS_PER_LINE)-1:0]      wr_idx,
    input  logic [WORD_WIDTH-1:0]                wr_data,
    output logic [WORD_WIDTH*WORDS_PER_LINE-1:0] data
);

    logic [WORD_WIDTH-1:0] slots [WORDS_PER_LINE];

    // Slot storage; a write lands only in the addressed word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WORDS_PER_LINE; i++) begin
                slots[i] <= '0;
            end
        end else if (wr_en) begin
            slots[wr_idx] <= wr_data;
        end
    end

    // Flatten slots so word k sits at bits [k*W +: W].
    always_comb begin
        data = '0;
        for (int k = 0; k < WORDS_PER_LINE; k++) begin
            data[k*WORD_WIDTH +: WORD_WIDTH] = slots[k];
        end
    end

endmodule

// File: rtl/fetch_line_assembler.sv
// Builds one fetch line from critical-word-first word reads.
// Handles redirects, draining responses still in flight.
module fetch_line_assembler
    import banff_fetch_pkg::*;
#(
    parameter int WORD_WIDTH     = DEF_WORD_WIDTH,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 flush,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic [ADDR_WIDTH-1:0]                req_addr,
    output logic                                 mem_req_valid,
    input  logic                                 mem_req_ready,
    output logic [ADDR_WIDTH-1:0]                mem_req_addr,
    input  logic                                 mem_rsp_valid,
    input  logic [WORD_WIDTH-1:0]                mem_rsp_data,
    output logic                                 line_valid,
    input  logic                                 line_ready,
    output logic [WORD_WIDTH*WORDS_PER_LINE-1:0] line_data,
    output logic [ADDR_WIDTH-1:0]                line_addr,
    output logic [log2(WORDS_PER_LINE)-1:0]      line_crit
);

    localparam int OFS  = log2(WORDS_PER_LINE);
    localparam int BOFS = log2(WORD_WIDTH / 8);
    localparam int CW   = OFS + 1;

    localparam logic [CW-1:0] FULL = CW'(WORDS_PER_LINE);
    localparam logic [CW-1:0] LAST = CW'(WORDS_PER_LINE - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    // Byte offset bits covering one whole line.
    localparam logic [ADDR_WIDTH-1:0] LMASK =
        ADDR_WIDTH'((64'd1 << (OFS + BOFS)) - 64'd1);

    fetch_state_e state;
    fetch_state_e state_nx;

    logic [ADDR_WIDTH-1:0] base;
    logic [OFS-1:0]        crit;
    logic [CW-1:0]         iss_cnt;
    logic [CW-1:0]         rsp_cnt;
    logic [CW-1:0]         drain_cnt;
    logic [CW-1:0]         out_cnt;

    logic           accept;
    logic           issue;
    logic           in_fill;
    logic           rsp_fill;
    logic           rsp_last;
    logic [OFS-1:0] iss_slot;
    logic [OFS-1:0] rsp_slot;

    assign in_fill = (state == FILL);

    // Request side: closed to new work while flushing.
    assign req_ready = (state == IDLE) && !flush;
    assign accept    = req_valid && req_ready;

    // Word issue: slots wrap inside the line from the critical word.
    assign iss_slot      = crit + iss_cnt[OFS-1:0];
    assign mem_req_valid = in_fill && (iss_cnt < FULL);
    assign mem_req_addr  = base + (ADDR_WIDTH'(iss_slot) << BOFS);
    assign issue         = mem_req_valid && mem_req_ready;

    // Responses arrive in issue order, so they follow the same wrap.
    assign rsp_slot = crit + rsp_cnt[OFS-1:0];
    assign rsp_fill = in_fill && mem_rsp_valid && !flush;
    assign rsp_last = mem_rsp_valid && (rsp_cnt == LAST);

    // Words still owed by memory if the line is abandoned now.
    assign out_cnt = iss_cnt + CW'(issue) - rsp_cnt - CW'(mem_rsp_valid);

    assign line_valid = (state == PRESENT);
    assign line_addr  = base;
    assign line_crit  = crit;

    fetch_line_buf #(
        .WORD_WIDTH    (WORD_WIDTH),
        .WORDS_PER_LINE(WORDS_PER_LINE)
    ) u_buf (
        .clock  (clock),
        .reset  (reset),
        .wr_en  (rsp_fill),
        .wr_idx (rsp_slot),
        .wr_data(mem_rsp_data),
        .data   (line_data)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state; flush overrides every other transition.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = FILL;
                end
            end
            FILL: begin
                if (flush) begin
                    state_nx = (out_cnt != '0) ? DRAIN : IDLE;
                end else if (rsp_last) begin
                    state_nx = PRESENT;
                end
            end
            PRESENT: begin
                if (flush || line_ready) begin
                    state_nx = IDLE;
                end
            end
            DRAIN: begin
                if (drain_cnt == '0) begin
                    state_nx = IDLE;
                end else if (mem_rsp_valid && drain_cnt == ONE) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Line base and critical offset, captured at request accept.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            base <= '0;
            crit <= '0;
        end else if (accept) begin
            base <= req_addr & ~LMASK;
            crit <= req_addr[BOFS +: OFS];
        end
    end

    // Issue and response counters for the line being filled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            iss_cnt <= '0;
            rsp_cnt <= '0;
        end else if (accept) begin
            iss_cnt <= '0;
            rsp_cnt <= '0;
        end else if (in_fill && !flush) begin
            if (issue) begin
                iss_cnt <= iss_cnt + ONE;
            end
            if (mem_rsp_valid) begin
                rsp_cnt <= rsp_cnt + ONE;
            end
        end
    end

    // Outstanding responses to swallow after a redirect.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drain_cnt <= '0;
        end else if (in_fill && flush) begin
            drain_cnt <= out_cnt;
        end else if (state == DRAIN && mem_rsp_valid && drain_cnt != '0) begin
            drain_cnt <= drain_cnt - ONE;
        end
    end

`ifndef SYNTHESIS
    // Flag responses that no fill or drain is waiting for.
    always @(posedge clock) begin
        if (!reset && mem_rsp_valid &&
            (state == IDLE || state == PRESENT)) begin
            $error("fetch_line_assembler: unexpected mem response");
        end
    end
`endif

endmodule

// File: tb/tb_fetch_line_assembler.sv
// Directed bench for fetch_line_assembler.
// Scenario tasks with hand-derived expected values.
module tb_fetch_line_assembler;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int AW = 32;

    logic            clock;
    logic            reset;
    logic            flush;
    logic            req_valid;
    logic            req_ready;
    logic [AW-1:0]   req_addr;
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [AW-1:0]   mem_req_addr;
    logic            mem_rsp_valid;
    logic [W-1:0]    mem_rsp_data;
    logic            line_valid;
    logic            line_ready;
    logic [W*N-1:0]  line_data;
    logic [AW-1:0]   line_addr;
    logic [1:0]      line_crit;

    int checks = 0;
    int errors = 0;

    // Memory model: answers each accepted word the following cycle.
    logic          mem_auto;
    logic          pend;
    logic          auto_v;
    logic [W-1:0]  auto_d;
    logic          man_v;
    logic [W-1:0]  man_d;
    logic [W-1:0]  rsp_base;
    int            rsp_idx;
    logic [AW-1:0] iss_q[$];

    assign mem_rsp_valid = mem_auto ? auto_v : man_v;
    assign mem_rsp_data  = mem_auto ? auto_d : man_d;

    fetch_line_assembler #(
        .WORD_WIDTH    (W),
        .WORDS_PER_LINE(N),
        .ADDR_WIDTH    (AW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_addr (mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data (mem_rsp_data),
        .line_valid   (line_valid),
        .line_ready   (line_ready),
        .line_data    (line_data),
        .line_addr    (line_addr),
        .line_crit    (line_crit)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (!reset && mem_req_valid && mem_req_ready) begin
            iss_q.push_back(mem_req_addr);
        end
        pend = mem_auto && !reset && mem_req_valid && mem_req_ready;
    end

    always @(posedge clock) begin
        #1;
        if (mem_auto) begin
            auto_v = pend;
            if (pend) begin
                auto_d = rsp_base + W'(rsp_idx);
                rsp_idx++;
            end
        end else begin
            auto_v = 1'b0;
        end
    end

    task automatic start_req(input logic [AW-1:0] addr);
        @(posedge clock);
        #1;
        iss_q.delete();
        rsp_idx   = 0;
        req_valid = 1'b1;
        req_addr  = addr;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_line(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (line_valid) begin
                cyc = i;
                return;
            end
        end
    endtask

    task automatic consume();
        @(posedge clock);
        #1;
        line_ready = 1'b1;
        @(posedge clock);
        #1;
        line_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++;
        if (line_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outs valid=%b memv=%b want 0 0",
                     line_valid, mem_req_valid);
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (line_data !== '0 || line_addr !== '0 || line_crit !== 2'd0) begin
            errors++;
            $display("FAIL reset_line data=%h addr=%h crit=%0d want 0",
                     line_data, line_addr, line_crit);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", req_ready);
        end
        flush     = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h40;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_flush_ready got %b want 0", req_ready);
        end
        @(posedge clock);
        #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (mem_req_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_flush_noaccept memv=%b rdy=%b want 0 1",
                     mem_req_valid, req_ready);
        end
    endtask

    task automatic test_aligned();
        int cyc;
        logic [AW-1:0] ea [4];
        ea = '{32'h100, 32'h104, 32'h108, 32'h10C};
        mem_auto      = 1'b1;
        mem_req_ready = 1'b1;
        rsp_base      = 32'hA0;
        start_req(32'h100);
        wait_line(cyc);
        checks++;
        if (cyc != 5) begin
            errors++;
            $display("FAIL aligned_latency got %0d want 5", cyc);
        end
        checks++;
        if (iss_q.size() != 4) begin
            errors++;
            $display("FAIL aligned_issues got %0d want 4", iss_q.size());
        end
        for (int i = 0; i < 4 && i < iss_q.size(); i++) begin
            checks++;
            if (iss_q[i] !== ea[i]) begin
                errors++;
                $display("FAIL aligned_addr%0d got %h want %h",
                         i, iss_q[i], ea[i]);
            end
        end
        checks++;
        if (line_data !== 128'h000000A3_000000A2_000000A1_000000A0) begin
            errors++;
            $display("FAIL aligned_data got %h", line_data);
        end
        checks++;
        if (line_addr !== 32'h100 || line_crit !== 2'd0) begin
            errors++;
            $display("FAIL aligned_meta addr=%h crit=%0d want 100 0",
                     line_addr, line_crit);
        end
        consume();
        @(negedge clock);
        checks++;
        if (line_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL aligned_done valid=%b rdy=%b want 0 1",
                     line_valid, req_ready);
        end
    endtask

    task automatic test_wrap();
        int cyc;
        logic [AW-1:0] ea [4];
        ea = '{32'h108, 32'h10C, 32'h100, 32'h104};
        rsp_base = 32'hD0;
        start_req(32'h108);
        wait_line(cyc);
        checks++;
        if (cyc != 5) begin
            errors++;
            $display("FAIL wrap_latency got %0d want 5", cyc);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (iss_q.size() <= i || iss_q[i] !== ea[i]) begin
                errors++;
                $display("FAIL wrap_addr%0d got %h want %h",
                         i, (iss_q.size() > i) ? iss_q[i] : 32'hx, ea[i]);
            end
        end
        checks++;
        if (line_data !== 128'h000000D1_000000D0_000000D3_000000D2) begin
            errors++;
            $display("FAIL wrap_data got %h", line_data);
        end
        checks++;
        if (line_addr !== 32'h100 || line_crit !== 2'd2) begin
            errors++;
            $display("FAIL wrap_meta addr=%h crit=%0d want 100 2",
                     line_addr, line_crit);
        end
        consume();
    endtask

    task automatic test_backpressure();
        logic          pat [4];
        logic [W*N-1:0] exp_d;
        int            cyc;
        pat   = '{1'b1, 1'b0, 1'b0, 1'b1};
        exp_d = 128'h00000032_00000031_00000030_00000033;
        rsp_base      = 32'h30;
        mem_req_ready = 1'b1;
        start_req(32'h304);
        cyc = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock);
            #1;
            mem_req_ready = pat[i % 4];
            @(negedge clock);
            if (line_valid) begin
                cyc = i;
                break;
            end
        end
        checks++;
        if (cyc < 0) begin
            errors++;
            $display("FAIL bp_timeout got no line_valid within 40 cycles");
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            mem_req_ready = pat[i % 4];
            @(negedge clock);
            checks++;
            if (line_valid !== 1'b1 || line_data !== exp_d ||
                req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d valid=%b rdy=%b data=%h want 1 0 %h",
                         i, line_valid, req_ready, line_data, exp_d);
            end
        end
        checks++;
        if (iss_q.size() != 4) begin
            errors++;
            $display("FAIL bp_issues got %0d want 4", iss_q.size());
        end
        @(posedge clock);
        #1;
        line_ready = 1'b1;
        @(negedge clock);
        checks++;
        if (req_ready !== 1'b0 || line_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_hs_cycle rdy=%b valid=%b want 0 1",
                     req_ready, line_valid);
        end
        @(posedge clock);
        #1;
        line_ready    = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clock);
        checks++;
        if (req_ready !== 1'b1 || line_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_after rdy=%b valid=%b want 1 0",
                     req_ready, line_valid);
        end
    endtask

    task automatic test_flush_drain();
        int cyc;
        mem_auto      = 1'b0;
        mem_req_ready = 1'b1;
        start_req(32'h40);
        @(posedge clock);
        #1;
        man_v = 1'b1;
        man_d = 32'hEE;
        @(posedge clock);
        #1;
        man_v = 1'b0;
        @(posedge clock);
        #1;
        mem_req_ready = 1'b0;
        flush         = 1'b1;
        @(negedge clock);
        checks++;
        if (iss_q.size() != 3 || mem_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre issues=%0d memv=%b want 3 1",
                     iss_q.size(), mem_req_valid);
        end
        @(posedge clock);
        #1;
        flush = 1'b0;
        man_v = 1'b1;
        man_d = 32'hBAD1;
        @(negedge clock);
        checks++;
        if (mem_req_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL drain_enter memv=%b rdy=%b want 0 0",
                     mem_req_valid, req_ready);
        end
        @(posedge clock);
        #1;
        man_v = 1'b0;
        @(posedge clock);
        #1;
        man_v = 1'b1;
        man_d = 32'hBAD2;
        @(negedge clock);
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL drain_hold rdy=%b want 0", req_ready);
        end
        @(posedge clock);
        #1;
        man_v = 1'b0;
        @(negedge clock);
        checks++;
        if (req_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_exit rdy=%b memv=%b want 1 0",
                     req_ready, mem_req_valid);
        end
        mem_req_ready = 1'b1;
        mem_auto      = 1'b1;
        rsp_base      = 32'h50;
        start_req(32'h200);
        wait_line(cyc);
        checks++;
        if (cyc != 5) begin
            errors++;
            $display("FAIL refill_latency got %0d want 5", cyc);
        end
        checks++;
        if (line_data !== 128'h00000053_00000052_00000051_00000050 ||
            line_addr !== 32'h200) begin
            errors++;
            $display("FAIL refill_line data=%h addr=%h want 53525150 200",
                     line_data, line_addr);
        end
        consume();
    endtask

    task automatic test_flush_present();
        int cyc;
        rsp_base = 32'h70;
        start_req(32'h404);
        wait_line(cyc);
        checks++;
        if (cyc != 5 || line_crit !== 2'd1) begin
            errors++;
            $display("FAIL fp_fill cyc=%0d crit=%0d want 5 1", cyc, line_crit);
        end
        @(posedge clock);
        #1;
        flush      = 1'b1;
        line_ready = 1'b1;
        @(negedge clock);
        checks++;
        if (line_valid !== 1'b1 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL fp_cycle valid=%b rdy=%b want 1 0",
                     line_valid, req_ready);
        end
        @(posedge clock);
        #1;
        flush      = 1'b0;
        line_ready = 1'b0;
        @(negedge clock);
        checks++;
        if (line_valid !== 1'b0 || req_ready !== 1'b1 ||
            mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL fp_after valid=%b rdy=%b memv=%b want 0 1 0",
                     line_valid, req_ready, mem_req_valid);
        end
    endtask

    task automatic test_async_reset();
        rsp_base = 32'h90;
        start_req(32'h3C8);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        mem_auto = 1'b0;
        man_v    = 1'b0;
        #2;
        checks++;
        if (mem_req_valid !== 1'b1 || line_addr !== 32'h3C0) begin
            errors++;
            $display("FAIL ar_pre memv=%b addr=%h want 1 3c0",
                     mem_req_valid, line_addr);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (mem_req_valid !== 1'b0 || line_valid !== 1'b0) begin
            errors++;
            $display("FAIL ar_immediate memv=%b valid=%b want 0 0",
                     mem_req_valid, line_valid);
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || line_addr !== '0 || line_crit !== 2'd0 ||
            line_data !== '0) begin
            errors++;
            $display("FAIL ar_release rdy=%b addr=%h crit=%0d data=%h",
                     req_ready, line_addr, line_crit, line_data);
        end
    endtask

    initial begin
        reset         = 1'b1;
        flush         = 1'b0;
        req_valid     = 1'b0;
        req_addr      = '0;
        mem_req_ready = 1'b0;
        line_ready    = 1'b0;
        mem_auto      = 1'b0;
        pend          = 1'b0;
        auto_v        = 1'b0;
        auto_d        = '0;
        man_v         = 1'b0;
        man_d         = '0;
        rsp_base      = '0;
        rsp_idx       = 0;
        test_reset();
        test_aligned();
        test_wrap();
        test_backpressure();
        test_flush_drain();
        test_flush_present();
        test_async_reset();
        repeat (2) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
